// File: rtl/layer_ctrl_pkg.sv
// Shared types and constants for the per-layer execution sequencer.
// Stage indices follow the fixed LN1 -> LIN2 chain of one transformer layer.
package layer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam int ST_LN1  = 0;
  localparam int ST_QKV  = 1;
  localparam int ST_ATTN = 2;
  localparam int ST_PROJ = 3;
  localparam int ST_LN2  = 4;
  localparam int ST_LIN1 = 5;
  localparam int ST_LIN2 = 6;

  localparam int NUM_STAGE_C = 7;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage wait counter: cleared when a stage is issued, counts while waiting,
// and flags expiry on the TIMEOUT_CYC-th consecutive idle wait cycle.
module stage_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
      localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC - 1);

      logic [W-1:0] count;

      // NOTE: sequential state is updated only with non-blocking assignments so
      // every always_ff reads the pre-edge value of every other register.
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          count <= '0;
        end else if (enable && (count != LIMIT)) begin
          count <= count + 1'b1;
        end
      end

      assign expire = enable && (count == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/layer_exec_ctrl.sv
// Runs one transformer layer per ln_start as a fixed chain of sub-engine stages,
// answers with linear2_done, tracks the layer index and flags protocol errors.
module layer_exec_ctrl
  import layer_ctrl_pkg::*;
#(
  parameter int NUM_LAYER   = 12,
  parameter int NUM_STAGE   = NUM_STAGE_C,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ln_start,
  input  logic [NUM_STAGE-1:0]         stage_done,
  input  logic                         err_clr,
  output logic [NUM_STAGE-1:0]         stage_start,
  output logic                         linear2_done,
  output logic                         busy,
  output logic [$clog2(NUM_LAYER)-1:0] layer_idx,
  output logic                         last_layer,
  output logic                         err_overlap,
  output logic                         err_spurious,
  output logic                         err_timeout
);

  localparam int SW = $clog2(NUM_STAGE);
  localparam int LW = $clog2(NUM_LAYER);
  localparam logic [SW-1:0] STAGE_MAX = SW'(NUM_STAGE - 1);
  localparam logic [LW-1:0] LAYER_MAX = LW'(NUM_LAYER - 1);

  state_t               state;
  logic [SW-1:0]        stage;
  logic [NUM_STAGE-1:0] stage_mask;
  logic [NUM_STAGE-1:0] spurious;
  logic                 done_hit;
  logic                 wd_expire;

  assign stage_mask = NUM_STAGE'(1) << stage;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    done_hit = 1'b0;
    spurious = stage_done;
    if (state == WAIT) begin
      done_hit = |(stage_done & stage_mask);
      spurious = stage_done & ~stage_mask;
    end
  end

  stage_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ISSUE),
    .enable ((state == WAIT) && !done_hit),
    .expire (wd_expire)
  );

  assign busy       = (state != IDLE);
  assign last_layer = (layer_idx == LAYER_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      stage        <= '0;
      layer_idx    <= '0;
      stage_start  <= '0;
      linear2_done <= 1'b0;
      err_overlap  <= 1'b0;
      err_spurious <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      stage_start  <= '0;
      linear2_done <= 1'b0;
      // A new error event outranks a simultaneous clear.
      err_overlap  <= (err_overlap  & ~err_clr) | (ln_start && (state != IDLE));
      err_spurious <= (err_spurious & ~err_clr) | (|spurious);
      err_timeout  <= (err_timeout  & ~err_clr) | wd_expire;

      case (state)
        IDLE: begin
          if (ln_start) begin
            stage       <= SW'(ST_LN1);
            stage_start <= NUM_STAGE'(1) << ST_LN1;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (done_hit) begin
            if (stage == STAGE_MAX) begin
              linear2_done <= 1'b1;
              state        <= DONE;
            end else begin
              stage       <= stage + 1'b1;
              stage_start <= stage_mask << 1;
              state       <= ISSUE;
            end
          end else if (wd_expire) begin
            state <= IDLE;
          end
        end
        DONE: begin
          layer_idx <= (layer_idx == LAYER_MAX) ? '0 : layer_idx + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_exec_ctrl.sv
// Scoreboard bench for layer_exec_ctrl: stimulus predicts every stage_start and
// linear2_done (cycle, index) from engine latencies; a monitor pops and compares.
module tb_layer_exec_ctrl;
  import layer_ctrl_pkg::*;

  localparam int NL = 12;
  localparam int NS = NUM_STAGE_C;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ln_start = 1'b0;
  logic          err_clr = 1'b0;
  logic [NS-1:0] stage_done = '0;
  logic [NS-1:0] stage_start;
  logic          linear2_done;
  logic          busy;
  logic [3:0]    layer_idx;
  logic          last_layer;
  logic          err_overlap;
  logic          err_spurious;
  logic          err_timeout;

  layer_exec_ctrl #(
    .NUM_LAYER  (NL),
    .NUM_STAGE  (NS),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ln_start    (ln_start),
    .stage_done  (stage_done),
    .err_clr     (err_clr),
    .stage_start (stage_start),
    .linear2_done(linear2_done),
    .busy        (busy),
    .layer_idx   (layer_idx),
    .last_layer  (last_layer),
    .err_overlap (err_overlap),
    .err_spurious(err_spurious),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit is_done;
    int idx;
    int cyc;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  int            lat[NS];
  int            hang_stage = -1;
  int            model_layer = 0;
  int            inj_cyc[2] = '{-1, -1};
  logic [NS-1:0] inj_mask[2];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int first_set(input logic [NS-1:0] v);
    for (int k = 0; k < NS; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic int start_cycle(input int t0, input int k);
    int c = t0 + 1;
    for (int j = 0; j < k; j++) c += lat[j] + 1;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Sub-engine models: each answers its start with a done pulse lat[k] cycles later.
  initial begin : engine
    int due[NS];
    foreach (due[k]) due[k] = -1;
    forever begin
      tick();
      stage_done = '0;
      if (rst) begin
        foreach (due[k]) due[k] = -1;
      end else begin
        for (int k = 0; k < NS; k++) begin
          if (due[k] == cyc) begin
            stage_done[k] = 1'b1;
            due[k] = -1;
          end
        end
        for (int j = 0; j < 2; j++) if (inj_cyc[j] == cyc) stage_done |= inj_mask[j];
        for (int k = 0; k < NS; k++) if (stage_start[k] && k != hang_stage) due[k] = cyc + lat[k];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ((|stage_start) || linear2_done)) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: got stage_start=%b linear2_done=%b at cycle %0d, expected no event",
                 stage_start, linear2_done, cyc);
      end else begin
        mon_e = q.pop_front();
        check("event_cycle", cyc, mon_e.cyc);
        check("event_kind", int'(linear2_done), int'(mon_e.is_done));
        if (mon_e.is_done) begin
          check("done_layer_idx", int'(layer_idx), mon_e.idx);
          check("done_no_start", int'(stage_start), 0);
        end else begin
          check("start_onehot", int'($onehot(stage_start)), 1);
          check("start_stage", first_set(stage_start), mon_e.idx);
        end
      end
    end
  end

  task automatic start_layer(input int hang, output int t0);
    exp_t e;
    t0 = cyc;
    for (int k = 0; k < NS; k++) begin
      e.is_done = 1'b0;
      e.idx     = k;
      e.cyc     = start_cycle(t0, k);
      q.push_back(e);
      if (k == hang) break;
    end
    if (hang < 0) begin
      e.is_done   = 1'b1;
      e.idx       = model_layer;
      e.cyc       = start_cycle(t0, NS);
      q.push_back(e);
      model_layer = (model_layer + 1) % NL;
    end
    hang_stage = hang;
    ln_start = 1'b1;
    tick();
    ln_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: got busy=%0d pending=%0d after %0d cycles, expected idle", busy, q.size(), n);
    end
  endtask

  task automatic check_idle(input int exp_layer);
    check("idle_stage_start", int'(stage_start), 0);
    check("idle_linear2_done", int'(linear2_done), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_layer_idx", int'(layer_idx), exp_layer);
    check("idle_last_layer", int'(last_layer), int'(exp_layer == NL - 1));
    check("idle_err_overlap", int'(err_overlap), 0);
    check("idle_err_spurious", int'(err_spurious), 0);
    check("idle_err_timeout", int'(err_timeout), 0);
  endtask

  task automatic pulse_clear();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin : global_guard
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int t0;
    int saved_idx;
    int n;

    foreach (lat[k]) lat[k] = 2;
    repeat (3) tick();
    check_idle(0);
    rst = 1'b0;
    tick();
    check_idle(0);

    // Nominal layer, every engine 2 cycles.
    start_layer(-1, t0);
    check("nominal_busy", int'(busy), 1);
    wait_idle();
    check_idle(1);

    // Remaining layers of a full inference with random engine latencies.
    for (int i = 1; i < NL; i++) begin
      repeat (3) tick();
      foreach (lat[k]) lat[k] = int'($urandom_range(8, 1));
      if (i == NL - 1) check("last_layer_before_12th", int'(last_layer), 1);
      start_layer(-1, t0);
      wait_idle();
    end
    check_idle(0);

    // Overlapping ln_start, coincident with err_clr: the event must win.
    foreach (lat[k]) lat[k] = 2;
    start_layer(-1, t0);
    wait_until(t0 + 5);
    ln_start = 1'b1;
    err_clr  = 1'b1;
    tick();
    ln_start = 1'b0;
    err_clr  = 1'b0;
    check("overlap_flag_set", int'(err_overlap), 1);
    wait_idle();
    check("overlap_flag_sticky", int'(err_overlap), 1);
    pulse_clear();
    check_idle(1);

    // Spurious done bits: foreign bit while waiting, then a foreign bit alongside the real one.
    lat = '{2, 6, 2, 3, 2, 2, 2};
    start_layer(-1, t0);
    inj_cyc[0]  = start_cycle(t0, 1) + 2;
    inj_mask[0] = NS'(1) << 4;
    inj_cyc[1]  = start_cycle(t0, 3) + lat[3];
    inj_mask[1] = NS'(1) << 0;
    wait_until(inj_cyc[0] + 1);
    check("spurious_flag_set", int'(err_spurious), 1);
    check("spurious_still_busy", int'(busy), 1);
    pulse_clear();
    check("spurious_flag_cleared", int'(err_spurious), 0);
    wait_idle();
    check("spurious_coincident_flag", int'(err_spurious), 1);
    inj_cyc = '{-1, -1};
    pulse_clear();
    check_idle(2);

    // Watchdog: engine 3 never answers.
    foreach (lat[k]) lat[k] = 2;
    saved_idx = int'(layer_idx);
    start_layer(ST_PROJ, t0);
    n = 0;
    while (!err_timeout && n < 200) begin
      tick();
      n++;
    end
    check("timeout_cycle", cyc, start_cycle(t0, ST_PROJ) + TO + 1);
    check("timeout_busy", int'(busy), 0);
    check("timeout_layer_idx", int'(layer_idx), saved_idx);
    check("timeout_all_starts_seen", q.size(), 0);
    repeat (3) tick();
    hang_stage = -1;
    pulse_clear();
    check_idle(saved_idx);

    // Reset during stage 5, then a fresh layer.
    foreach (lat[k]) lat[k] = 4;
    start_layer(-1, t0);
    wait_until(start_cycle(t0, ST_LIN1) + 1);
    rst = 1'b1;
    q.delete();
    model_layer = 0;
    tick();
    check_idle(0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_idle(0);
    foreach (lat[k]) lat[k] = 2;
    start_layer(-1, t0);
    wait_idle();
    check_idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
